// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scan-out owns the RAM during active video; buffered
// writer requests (and the optional full-frame clear, VGA_FB_CLEAR_EN) drain in blanking.
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_rgb
);

  localparam int unsigned       AREA      = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(AREA - 1);
  localparam int unsigned       PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef VGA_FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, SCAN, FIFO_WR, CLR_WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN, FIFO_WR} state_t;
`endif

  state_t state;

  // Writer FIFO
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              clr_active;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  assign fifo_empty = (count == '0);
  assign wr_ready   = (count != CNT_FULL);
  assign push       = wr_valid && wr_ready;
  assign pop        = !valid && !clr_active && !fifo_empty;
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

`ifdef VGA_FB_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;

  // Counter only advances on blanking cycles, matching the CLR_WR owner decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_busy  <= 1'b0;
      clr_cnt   <= '0;
      clr_color <= '0;
    end else if (!clr_busy) begin
      if (clear_req) begin
        clr_busy  <= 1'b1;
        clr_cnt   <= '0;
        clr_color <= clear_color;
      end
    end else if (!valid) begin
      if (clr_cnt == LAST_ADDR) clr_busy <= 1'b0;
      else                      clr_cnt  <= clr_cnt + ADDR_W'(1);
    end
  end

  assign clr_active = clr_busy;
  assign clear_busy = clr_busy;
`else
  logic unused_clear;
  assign unused_clear = ^{clear_req, clear_color};
  assign clr_active   = 1'b0;
  assign clear_busy   = 1'b0;
`endif

  // Owner decision; an out-of-range FIFO entry is popped without issuing a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (valid) begin
        state    <= SCAN;
        mem_addr <= ADDR_W'(32'(y) * H_ACTIVE + 32'(x));
`ifdef VGA_FB_CLEAR_EN
      end else if (clr_active) begin
        state     <= CLR_WR;
        mem_addr  <= clr_cnt;
        mem_we    <= 1'b1;
        mem_wdata <= clr_color;
`endif
      end else if (pop) begin
        state <= FIFO_WR;
        if (head_addr <= LAST_ADDR) begin
          mem_addr  <= head_addr;
          mem_we    <= 1'b1;
          mem_wdata <= head_data;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

  // state==SCAN is valid delayed by one; scan_d supplies the second stage.
  logic scan_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_d  <= 1'b0;
      pix_rgb <= '0;
    end else begin
      scan_d  <= (state == SCAN);
      pix_rgb <= scan_d ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: frame-level model (write queue + golden frame) compared every
// cycle, plus directed literal checks. Smaller frame when VGA_FB_CLEAR_EN is defined.
module tb_vga_fb_arbiter;

`ifdef VGA_FB_CLEAR_EN
  localparam int unsigned H = 32;
  localparam int unsigned V = 16;
`else
  localparam int unsigned H = 640;
  localparam int unsigned V = 480;
`endif
  localparam int unsigned AREA = H * V;
  localparam int unsigned AW   = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [9:0]    x, y;
  logic          valid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [2:0]    wr_data;
  logic          clear_req;
  logic [2:0]    clear_color;
  logic          clear_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [2:0]    mem_wdata;
  logic [2:0]    mem_rdata = 3'b000;
  logic [2:0]    pix_rgb;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .valid(valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_rgb(pix_rgb)
  );

  function automatic bit [2:0] init_val(int unsigned i);
    if (i == H + 1) return 3'b101;
    return 3'((i * 7 + 3) % 8);
  endfunction

  // Synchronous single-port RAM
  bit [2:0] ram [0:(1<<AW)-1];
  bit       ram_loaded;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < AREA; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: pending writes queue, golden frame contents, clear progress
  typedef struct { int unsigned a; int unsigned d; } wr_t;
  wr_t          q[$];
  bit [2:0]     frame [AREA];
  int unsigned  e_addr, e_wdata, e_pix, d0, d1, m_cnt, m_color;
  bit           e_we, m_busy;

  task automatic model_step();
    bit ready_pre;
    bit busy_pre;
    wr_t w;
    int unsigned a;
    ready_pre = (q.size() < 4);
    busy_pre  = m_busy;
    e_pix = d1;
    d1    = d0;
    e_we  = 1'b0;
    if (valid) begin
      a      = 32'(y) * H + 32'(x);
      e_addr = a % (1 << AW);
      d0     = (a < AREA) ? frame[a] : 0;
    end else begin
      d0 = 0;
      if (busy_pre) begin
        e_we = 1'b1; e_addr = m_cnt; e_wdata = m_color;
        frame[m_cnt] = 3'(m_color);
        if (m_cnt == AREA - 1) m_busy = 1'b0;
        else m_cnt++;
      end else if (q.size() != 0) begin
        w = q.pop_front();
        if (w.a < AREA) begin
          e_we = 1'b1; e_addr = w.a; e_wdata = w.d;
          frame[w.a] = 3'(w.d);
        end
      end
    end
    if (wr_valid && ready_pre) q.push_back('{a: wr_addr, d: wr_data});
`ifdef VGA_FB_CLEAR_EN
    if (!busy_pre && clear_req) begin
      m_busy = 1'b1; m_cnt = 0; m_color = clear_color;
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < AREA; i++) frame[i] = init_val(i);
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        e_addr = 0; e_we = 1'b0; e_wdata = 0; e_pix = 0; d0 = 0; d1 = 0;
        m_busy = 1'b0; m_cnt = 0; m_color = 0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      chk("pix_rgb", pix_rgb, e_pix);
      chk("wr_ready", wr_ready, (q.size() < 4) ? 1 : 0);
      chk("clear_busy", clear_busy, m_busy);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  bit [2:0] sweep_tbl [8];

  initial begin
    valid = 1'b0; x = '0; y = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clear_req = 1'b0; clear_color = '0;
    sweep_tbl = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd7, 3'd3, 3'd5, 3'd4};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pix", pix_rgb, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_busy", clear_busy, 0);
    rst = 1'b1;
    tick();

    // Scan read of (1,1)
    valid = 1'b1; x = 10'd1; y = 10'd1;
    tick();
    chk("scan_addr", mem_addr, H + 1);
    chk("scan_we", mem_we, 0);
    valid = 1'b0;
    tick();
    tick();
    chk("scan_pix", pix_rgb, 3'b101);

    // Three writes queued during active video, drained in blanking
    valid = 1'b1; y = 10'd2;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = 10'(100 + i); wr_addr = AW'(i); wr_data = 3'(i + 1);
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x = 10'(103 + i);
      tick();
      chk("active_no_we", mem_we, 0);
    end
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("blank_we", mem_we, 1);
      chk("blank_addr", mem_addr, i);
      chk("blank_data", mem_wdata, i + 1);
    end
    tick();
    chk("blank_idle", mem_we, 0);

    // Full FIFO: 4 accepted, 5th held until first blanking pop
    valid = 1'b1; y = 10'd3; wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x = 10'(i); wr_addr = AW'(10 + i); wr_data = 3'(i + 4);
      chk("ready_before_push", wr_ready, 1);
      tick();
    end
    chk("ready_full", wr_ready, 0);
    wr_addr = AW'(20); wr_data = 3'd7;
    tick();
    tick();
    chk("ready_held", wr_ready, 0);
    valid = 1'b0;
    tick();
    chk("pop_we", mem_we, 1);
    chk("pop_addr", mem_addr, 10);
    chk("ready_after_pop", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    repeat (5) tick();

    // Out-of-range write is consumed but never reaches the RAM
    valid = 1'b1; y = 10'd4; wr_valid = 1'b1;
    wr_addr = AW'(AREA); wr_data = 3'd6;
    tick();
    wr_addr = AW'(5); wr_data = 3'd3;
    tick();
    wr_valid = 1'b0; valid = 1'b0;
    tick();
    chk("oor_dropped", mem_we, 0);
    tick();
    chk("after_oor_we", mem_we, 1);
    chk("after_oor_addr", mem_addr, 5);
    chk("after_oor_data", mem_wdata, 3);
    tick();

    // Read back line 0 through the scan path
    y = 10'd0;
    for (int k = 0; k < 10; k++) begin
      valid = (k < 8);
      x = 10'(k);
      tick();
      if (k >= 2) chk("sweep_pix", pix_rgb, sweep_tbl[k-2]);
    end
    valid = 1'b0;
    tick();

`ifdef VGA_FB_CLEAR_EN
    begin
      bit done;
      clear_color = 3'b010; clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      chk("clear_busy_set", clear_busy, 1);
      wr_valid = 1'b1; wr_addr = AW'(7); wr_data = 3'd6;
      tick();
      wr_valid = 1'b0;
      chk("clear_first_we", mem_we, 1);
      chk("clear_first_addr", mem_addr, 0);
      chk("clear_first_data", mem_wdata, 2);
      done = 1'b0;
      for (int c = 0; c < 4 * AREA && !done; c++) begin
        valid = (c % 4 == 0);
        x = 10'(c % H); y = 10'd1;
        clear_req = (c == 50); clear_color = 3'b101;
        tick();
        if (!clear_busy) done = 1'b1;
      end
      clear_req = 1'b0;
      chk("clear_done", done, 1);
      valid = 1'b0;
      repeat (3) tick();
      y = 10'd0;
      for (int k = 0; k < 10; k++) begin
        valid = (k < 8);
        x = 10'(k);
        tick();
        if (k >= 2) chk("clear_pix", pix_rgb, (k - 2 == 7) ? 6 : 2);
      end
      valid = 1'b0;
      tick();
    end
`else
    clear_color = 3'b010; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("noclear_busy", clear_busy, 0);
    chk("noclear_we", mem_we, 0);
    tick();
`endif

    // Async reset with writes pending
    valid = 1'b1; y = 10'd4; wr_valid = 1'b1;
    wr_addr = AW'(30); wr_data = 3'd1;
    tick();
    wr_addr = AW'(31); wr_data = 3'd2;
    tick();
    wr_valid = 1'b0; valid = 1'b0;
    tick();
    chk("drain_we", mem_we, 1);
    chk("drain_addr", mem_addr, 30);
    rst = 1'b0;
    #1;
    chk("arst_we", mem_we, 0);
    chk("arst_pix", pix_rgb, 0);
    chk("arst_busy", clear_busy, 0);
    chk("arst_ready", wr_ready, 1);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale_we", mem_we, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
